oven_display_seq: RTL and testbench

Sequential, parametrised display controller for the oven's six active-low 7-segment digits (hex5..hex0). Each frame snapshots the oven state, converts binary temperature and seconds to BCD over multiple cycles (restoring divide-by-60, then shift-add-3), and commits the frame atomically. Adds behaviour the combinational decoder lacked: glitch-free frame commit, saturation, blinking of the field being edited, and a cooking mode that alternates between remaining time and current temperature. Sits between the oven control FSM and the board HEX pins.

---
 rtl/oven_display_seq.sv | 254 +++++++++++++++++++++++++
 tb/tb_oven_display_seq.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/oven_display_seq.sv
// Six-digit active-low 7-segment display sequencer for the oven: per-frame snapshot, divide-by-60, double-dabble, atomic commit.
// Define LEAD_ZERO_BLANK_EN to blank leading zeros of temperature and minutes tens.
module oven_display_seq #(
  parameter int TEMP_W         = 10,
  parameter int TIME_W         = 13,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BLINK_CYCLES   = 12500000,
  parameter int ALT_FRAMES     = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              power,
  input  logic              tempInputDone,
  input  logic              timeInputDone,
  input  logic [TEMP_W-1:0] current_temp,
  input  logic [TEMP_W-1:0] target_temp,
  input  logic [TIME_W-1:0] current_time,
  input  logic [TIME_W-1:0] target_time,
  output logic [0:6]        hex0,
  output logic [0:6]        hex1,
  output logic [0:6]        hex2,
  output logic [0:6]        hex3,
  output logic [0:6]        hex4,
  output logic [0:6]        hex5,
  output logic              busy,
  output logic              frame_done
);
  typedef enum logic [2:0] {S_IDLE, S_SNAP, S_DIV, S_BCD, S_COMMIT} state_t;
  typedef enum logic [1:0] {M_OFF, M_TEMP, M_TIME, M_COOK} mode_t;

  localparam int STEP_MAX = (TIME_W > TEMP_W) ? TIME_W : TEMP_W;
  localparam int STEP_W   = $clog2(STEP_MAX + 1);
  localparam int RC_W     = $clog2(REFRESH_CYCLES + 1);
  localparam int BC_W     = $clog2(BLINK_CYCLES + 1);
  localparam int AC_W     = $clog2(ALT_FRAMES + 1);
  localparam logic [0:6] BLANK = 7'b1111111;
  localparam logic [0:6] DASH  = 7'b1111110;
  localparam logic [0:6] SEG_T = 7'b1110000;
  localparam logic [0:6] SEG_C = 7'b0110001;

  state_t state, state_n;
  mode_t  mode_in, snap_mode, prev_mode, buf_mode, src_mode;
  logic [STEP_W-1:0] step;
  logic [TIME_W-1:0] time_sel, div_q, div_q_n;
  logic [TEMP_W-1:0] temp_sel, temp_clamp, temp_sh, min_sh, sec_sh;
  logic [5:0]  div_r, div_r_n, sec_c;
  logic [6:0]  div_trial, min_c;
  logic        div_ge;
  logic [11:0] bcd_t, buf_t, src_t;
  logic [7:0]  bcd_m, bcd_s, buf_m, buf_s, src_m, src_s;
  logic        buf_valid, buf_alt, src_valid, src_alt;
  logic [RC_W-1:0] refresh_cnt;
  logic [BC_W-1:0] blink_cnt;
  logic [AC_W-1:0] alt_cnt;
  logic        pending, refresh_wrap, blink_phase, alt_phase;
  logic        t2_blank, t1_blank, m1_blank;
  logic [0:6]  d_t2, d_t1, d_t0, d_m1, d_m0, d_s1, d_s0;
  logic [0:6]  r0, r1, r2, r3, r4, r5;

  function automatic logic [0:6] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = 7'b0000001;
      4'd1: seg = 7'b1001111;
      4'd2: seg = 7'b0010010;
      4'd3: seg = 7'b0000110;
      4'd4: seg = 7'b1001100;
      4'd5: seg = 7'b0100100;
      4'd6: seg = 7'b0100000;
      4'd7: seg = 7'b0001111;
      4'd8: seg = 7'b0000000;
      4'd9: seg = 7'b0000100;
      default: seg = 7'b1111111;
    endcase
  endfunction

  // One double-dabble step: add 3 to every digit >= 5, then shift the next binary bit in.
  function automatic logic [11:0] dabble(input logic [11:0] b, input logic bit_in);
    logic [11:0] a;
    a = b;
    for (int i = 0; i < 3; i++)
      if (a[i*4 +: 4] >= 4'd5) a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    return {a[10:0], bit_in};
  endfunction

  assign busy       = (state != S_IDLE);
  assign frame_done = (state == S_COMMIT);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   if (pending) state_n = S_SNAP;
      S_SNAP:   state_n = S_DIV;
      S_DIV:    if (step == STEP_W'(TIME_W - 1)) state_n = S_BCD;
      S_BCD:    if (step == STEP_W'(TEMP_W - 1)) state_n = S_COMMIT;
      S_COMMIT: state_n = S_IDLE;
      default:  state_n = S_IDLE;
    endcase
  end

  always_comb begin
    mode_in = M_COOK;
    if (!power)              mode_in = M_OFF;
    else if (!tempInputDone) mode_in = M_TEMP;
    else if (!timeInputDone) mode_in = M_TIME;
    case (mode_in)
      M_TIME:  time_sel = target_time;
      M_COOK:  time_sel = (current_time >= target_time) ? '0 : target_time - current_time;
      default: time_sel = current_time;
    endcase
    temp_sel   = (mode_in == M_TEMP) ? target_temp : current_temp;
    temp_clamp = (int'(temp_sel) > 999) ? TEMP_W'(999) : temp_sel;
  end

  // Restoring divide-by-60, MSB first; remainder always stays below 60 between steps.
  always_comb begin
    div_trial = {div_r, div_q[TIME_W-1]};
    div_ge    = (div_trial >= 7'd60);
    div_r_n   = div_ge ? 6'(div_trial - 7'd60) : div_trial[5:0];
    div_q_n   = {div_q[TIME_W-2:0], div_ge};
    min_c     = (int'(div_q_n) > 99) ? 7'd99 : 7'(div_q_n);
    sec_c     = (int'(div_q_n) > 99) ? 6'd59 : div_r_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      step <= '0; snap_mode <= M_OFF; prev_mode <= M_OFF;
      div_q <= '0; div_r <= '0; temp_sh <= '0; min_sh <= '0; sec_sh <= '0;
      bcd_t <= '0; bcd_m <= '0; bcd_s <= '0;
      buf_valid <= 1'b0; buf_mode <= M_OFF; buf_alt <= 1'b0;
      buf_t <= '0; buf_m <= '0; buf_s <= '0;
      alt_cnt <= '0; alt_phase <= 1'b0;
    end else begin
      case (state)
        S_SNAP: begin
          snap_mode <= mode_in;
          prev_mode <= mode_in;
          div_q <= time_sel; div_r <= '0; temp_sh <= temp_clamp;
          bcd_t <= '0; bcd_m <= '0; bcd_s <= '0; step <= '0;
          if (mode_in == M_COOK && prev_mode != M_COOK) begin
            alt_cnt <= '0; alt_phase <= 1'b0;
          end
        end
        S_DIV: begin
          div_q <= div_q_n;
          div_r <= div_r_n;
          if (step == STEP_W'(TIME_W - 1)) begin
            step   <= '0;
            min_sh <= TEMP_W'(min_c);
            sec_sh <= TEMP_W'(sec_c);
          end else step <= step + STEP_W'(1);
        end
        S_BCD: begin
          bcd_t   <= dabble(bcd_t, temp_sh[TEMP_W-1]);
          bcd_m   <= 8'(dabble({4'b0, bcd_m}, min_sh[TEMP_W-1]));
          bcd_s   <= 8'(dabble({4'b0, bcd_s}, sec_sh[TEMP_W-1]));
          temp_sh <= temp_sh << 1;
          min_sh  <= min_sh << 1;
          sec_sh  <= sec_sh << 1;
          step    <= step + STEP_W'(1);
        end
        S_COMMIT: begin
          buf_valid <= 1'b1; buf_mode <= snap_mode; buf_alt <= alt_phase;
          buf_t <= bcd_t; buf_m <= bcd_m; buf_s <= bcd_s;
          if (snap_mode == M_COOK) begin
            if (alt_cnt == AC_W'(ALT_FRAMES - 1)) begin
              alt_cnt <= '0; alt_phase <= ~alt_phase;
            end else alt_cnt <= alt_cnt + AC_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign refresh_wrap = (refresh_cnt == RC_W'(REFRESH_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      refresh_cnt <= '0; pending <= 1'b1; blink_cnt <= '0; blink_phase <= 1'b0;
    end else begin
      refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + RC_W'(1);
      // Holds at most one request; it is consumed when IDLE launches a frame.
      pending <= refresh_wrap | (pending & (state != S_IDLE));
      if (blink_cnt == BC_W'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0; blink_phase <= ~blink_phase;
      end else blink_cnt <= blink_cnt + BC_W'(1);
    end
  end

  // During COMMIT the freshly converted frame is rendered so the pins change exactly one cycle later.
  always_comb begin
    src_valid = buf_valid | (state == S_COMMIT);
    src_mode  = (state == S_COMMIT) ? snap_mode : buf_mode;
    src_alt   = (state == S_COMMIT) ? alt_phase : buf_alt;
    src_t     = (state == S_COMMIT) ? bcd_t : buf_t;
    src_m     = (state == S_COMMIT) ? bcd_m : buf_m;
    src_s     = (state == S_COMMIT) ? bcd_s : buf_s;
`ifdef LEAD_ZERO_BLANK_EN
    t2_blank = (src_t[11:8] == 4'd0);
    t1_blank = (src_t[11:8] == 4'd0) && (src_t[7:4] == 4'd0);
    m1_blank = (src_m[7:4] == 4'd0);
`else
    t2_blank = 1'b0;
    t1_blank = 1'b0;
    m1_blank = 1'b0;
`endif
    d_t2 = t2_blank ? BLANK : seg(src_t[11:8]);
    d_t1 = t1_blank ? BLANK : seg(src_t[7:4]);
    d_t0 = seg(src_t[3:0]);
    d_m1 = m1_blank ? BLANK : seg(src_m[7:4]);
    d_m0 = seg(src_m[3:0]);
    d_s1 = seg(src_s[7:4]);
    d_s0 = seg(src_s[3:0]);
    r0 = BLANK; r1 = BLANK; r2 = BLANK; r3 = BLANK; r4 = BLANK; r5 = BLANK;
    if (src_valid) begin
      case (src_mode)
        M_OFF: begin
          r4 = d_m1; r3 = d_m0; r2 = DASH; r1 = d_s1; r0 = d_s0;
        end
        M_TEMP: if (!blink_phase) begin
          r2 = d_t2; r1 = d_t1; r0 = d_t0;
        end
        M_TIME: begin
          r2 = DASH;
          if (!blink_phase) begin
            r4 = d_m1; r3 = d_m0; r1 = d_s1; r0 = d_s0;
          end
        end
        default: begin
          if (!src_alt) begin
            r5 = SEG_T; r4 = d_m1; r3 = d_m0; r2 = DASH; r1 = d_s1; r0 = d_s0;
          end else begin
            r5 = SEG_C; r2 = d_t2; r1 = d_t1; r0 = d_t0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex0 <= BLANK; hex1 <= BLANK; hex2 <= BLANK;
      hex3 <= BLANK; hex4 <= BLANK; hex5 <= BLANK;
    end else begin
      hex0 <= r0; hex1 <= r1; hex2 <= r2;
      hex3 <= r3; hex4 <= r4; hex5 <= r5;
    end
  end
endmodule

// File: tb/tb_oven_display_seq.sv
// Directed bench for oven_display_seq: short refresh/blink/alt periods, hand-computed display words.
module tb_oven_display_seq;
  localparam int TEMP_W = 10;
  localparam int TIME_W = 13;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010, S3 = 7'b0000110;
  localparam logic [6:0] S5 = 7'b0100100, S4 = 7'b1001100, S7 = 7'b0001111, S9 = 7'b0000100;
  localparam logic [6:0] BL = 7'b1111111, DS = 7'b1111110, ST = 7'b1110000, SC = 7'b0110001;
`ifdef LEAD_ZERO_BLANK_EN
  localparam logic [6:0] LZ = BL;
`else
  localparam logic [6:0] LZ = S0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic power = 1'b1, tempInputDone = 1'b0, timeInputDone = 1'b0;
  logic [TEMP_W-1:0] current_temp = '0, target_temp = '0;
  logic [TIME_W-1:0] current_time = '0, target_time = '0;
  logic [0:6] hex0, hex1, hex2, hex3, hex4, hex5;
  logic busy, frame_done;
  logic [41:0] hex_all;

  int total = 0;
  int bad = 0;

  oven_display_seq #(
    .TEMP_W(TEMP_W), .TIME_W(TIME_W), .REFRESH_CYCLES(10), .BLINK_CYCLES(4), .ALT_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .power(power), .tempInputDone(tempInputDone),
    .timeInputDone(timeInputDone), .current_temp(current_temp), .target_temp(target_temp),
    .current_time(current_time), .target_time(target_time),
    .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3), .hex4(hex4), .hex5(hex5),
    .busy(busy), .frame_done(frame_done)
  );

  assign hex_all = {hex5, hex4, hex3, hex2, hex1, hex0};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Returns one cycle after the next COMMIT, when the new frame is on the pins.
  task automatic next_frame();
    int n;
    n = 0;
    while (frame_done !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("frame_timeout", 64'(n < 200), 64'(1));
    tick();
  endtask

  task automatic count_latency(input string tag);
    int n;
    tick();
    chk({tag, "_busy_rise"}, 64'(busy), 64'(1));
    n = 1;
    while (frame_done !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_latency"}, 64'(n), 64'(25));
    tick();
    chk({tag, "_done_pulse"}, 64'(frame_done), 64'(0));
  endtask

  initial begin
    logic [41:0] lit_pat, blk_pat, v;
    bit s[24];
    int first, k;

    // Reset and first TEMP_ENTRY frame
    power = 1'b1; tempInputDone = 1'b0; timeInputDone = 1'b0; target_temp = 10'd350;
    tick(); tick(); tick();
    chk("reset_hex", 64'(hex_all), 64'({BL, BL, BL, BL, BL, BL}));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_done", 64'(frame_done), 64'(0));
    reset = 1'b0;
    count_latency("first");
    chk("temp_350", 64'(hex_all), 64'({BL, BL, BL, S3, S5, S0}));

    // Clock display
    power = 1'b0; current_time = 13'd754;
    next_frame();
    chk("off_754", 64'(hex_all), 64'({BL, S1, S2, DS, S3, S4}));
    current_time = 13'd8191;
    next_frame();
    chk("off_sat", 64'(hex_all), 64'({BL, S9, S9, DS, S5, S9}));

    // Temperature entry with saturation; wait out a blank blink phase
    power = 1'b1; tempInputDone = 1'b0; target_temp = 10'd1023;
    next_frame();
    k = 0;
    while (hex0 === BL && k < 12) begin
      tick();
      k++;
    end
    chk("temp_sat", 64'(hex_all), 64'({BL, BL, BL, S9, S9, S9}));

    // Time entry blinking every 4 clocks
    tempInputDone = 1'b1; timeInputDone = 1'b0; target_time = 13'd90;
    next_frame();
    next_frame();
    lit_pat = {BL, LZ, S1, DS, S3, S0};
    blk_pat = {BL, BL, BL, DS, BL, BL};
    for (int i = 0; i < 24; i++) begin
      tick();
      v = hex_all;
      chk("blink_pattern", 64'((v === lit_pat) || (v === blk_pat)), 64'(1));
      s[i] = (v === lit_pat);
    end
    first = -1;
    for (int i = 1; i < 8; i++)
      if (first < 0 && s[i] != s[i-1]) first = i;
    chk("blink_edge_found", 64'(first > 0), 64'(1));
    if (first > 0)
      for (int j = first; j < first + 16; j++)
        chk("blink_period", 64'(s[j]), 64'(s[first] ^ (((j - first) / 4) % 2 == 1)));

    // Cook mode alternation: t,t,C,C,t
    next_frame();
    timeInputDone = 1'b1; target_time = 13'd300; current_time = 13'd120; current_temp = 10'd75;
    next_frame();
    chk("cook_f1", 64'(hex_all), 64'({ST, LZ, S3, DS, S0, S0}));
    next_frame();
    chk("cook_f2", 64'(hex_all), 64'({ST, LZ, S3, DS, S0, S0}));
    next_frame();
    chk("cook_f3", 64'(hex_all), 64'({SC, BL, BL, LZ, S7, S5}));
    next_frame();
    chk("cook_f4", 64'(hex_all), 64'({SC, BL, BL, LZ, S7, S5}));
    next_frame();
    chk("cook_f5", 64'(hex_all), 64'({ST, LZ, S3, DS, S0, S0}));
    current_time = 13'd400;
    next_frame();
    chk("cook_expired", 64'(hex_all), 64'({ST, LZ, S0, DS, S0, S0}));

    // Back-to-back frames: one idle cycle, fixed 26-cycle spacing
    for (int r = 0; r < 2; r++) begin
      chk("b2b_idle_busy", 64'(busy), 64'(0));
      count_latency("b2b");
    end

    // Reset during DIV cycle 5
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    chk("abort_done", 64'(frame_done), 64'(0));
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_hex", 64'(hex_all), 64'({BL, BL, BL, BL, BL, BL}));
    tick();
    chk("abort_hold_done", 64'(frame_done), 64'(0));
    reset = 1'b0;
    count_latency("restart");
    chk("restart_hex", 64'(hex_all), 64'({ST, LZ, S0, DS, S0, S0}));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
